speedgoal_ctrl: RTL

Front-end controller that sequences the speed-goal register from the board pushbuttons. It debounces the up, down and zero keys and emits single-cycle `up` / `down` step pulses, with hold-to-repeat and optional acceleration, plus a one-cycle `goal_srst` pulse. It sits between the raw KEY inputs and the goal register's `up` / `down` / `srst` inputs, and is the only block that drives them.

---
 rtl/speedgoal_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/speedgoal_ctrl.sv
// speedgoal_ctrl: debounces the up/down/zero pushbuttons and drives the goal register's up/down/srst pulses.
// Optional macro SPEEDGOAL_ACCEL_EN: after FAST_AFTER repeat steps, auto-repeat switches to REPEAT_FAST_CYC.
module speedgoal_ctrl #(
    parameter int unsigned DEBOUNCE_CYC     = 500000,
    parameter int unsigned REPEAT_DELAY_CYC = 25000000,
    parameter int unsigned REPEAT_SLOW_CYC  = 5000000,
    parameter int unsigned REPEAT_FAST_CYC  = 500000,
    parameter int unsigned FAST_AFTER       = 8,
    parameter int unsigned CNT_W            = 25
) (
    input  logic clk,
    input  logic arst_n,
    input  logic key_up_n,
    input  logic key_down_n,
    input  logic key_zero_n,
    output logic up,
    output logic down,
    output logic goal_srst,
    output logic holding
);

    localparam int unsigned REP_W = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);

`ifdef SPEEDGOAL_ACCEL_EN
    localparam bit ACCEL_EN = 1'b1;
`else
    localparam bit ACCEL_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(REPEAT_SLOW_CYC - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(REPEAT_FAST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_DB,
        S_DELAY,
        S_REPEAT,
        S_REL_DB
    } state_t;

    typedef enum logic [1:0] {
        SEL_UP,
        SEL_DOWN,
        SEL_ZERO
    } sel_t;

    state_t           r_state;
    sel_t             r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_key_meta;     // {zero, down, up}, active low
    logic [2:0]       r_key_sync;
    logic [2:0]       r_pulse;        // {goal_srst, down, up}
    logic             r_holding;

    logic [2:0]       w_pressed;
    logic [2:0]       w_sel_mask;
    logic             w_sel_held;
    logic             w_other;
    logic             w_abort;
    logic             w_fast;
    logic [REP_W-1:0] w_rep;
    logic [CNT_W-1:0] w_period_last;

    // Two-flop synchronizers; reset to the released level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
        end else begin
            r_key_meta <= {key_zero_n, key_down_n, key_up_n};
            r_key_sync <= r_key_meta;
        end
    end

    assign w_pressed = ~r_key_sync;

    always_comb begin
        w_sel_mask = 3'b000;
        case (r_sel)
            SEL_UP:   w_sel_mask = 3'b001;
            SEL_DOWN: w_sel_mask = 3'b010;
            SEL_ZERO: w_sel_mask = 3'b100;
            default:  w_sel_mask = 3'b000;
        endcase
    end

    assign w_sel_held = |(w_pressed & w_sel_mask);
    assign w_other    = |(w_pressed & ~w_sel_mask);
    assign w_abort    = !w_sel_held || w_other;

`ifdef SPEEDGOAL_ACCEL_EN
    logic [REP_W-1:0] r_rep;
    assign w_rep = r_rep;
`else
    assign w_rep = '0;
`endif

    assign w_fast        = ACCEL_EN && (w_rep >= REP_W'(FAST_AFTER));
    assign w_period_last = w_fast ? FAST_LAST : SLOW_LAST;

    // Abort checks come before terminal counts so a release on the last count never pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= SEL_UP;
            r_cnt     <= '0;
            r_pulse   <= '0;
            r_holding <= 1'b0;
`ifdef SPEEDGOAL_ACCEL_EN
            r_rep     <= '0;
`endif
        end else begin
            r_pulse <= '0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_pressed[2]) begin
                        r_sel   <= SEL_ZERO;
                        r_state <= S_PRESS_DB;
                    end else if (w_pressed[0] != w_pressed[1]) begin
                        r_sel   <= w_pressed[0] ? SEL_UP : SEL_DOWN;
                        r_state <= S_PRESS_DB;
                    end
                end
                S_PRESS_DB: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == DB_LAST) begin
                        r_pulse <= w_sel_mask;
                        r_cnt   <= '0;
                        if (r_sel == SEL_ZERO) begin
                            r_state <= S_REL_DB;
                        end else begin
                            r_state   <= S_DELAY;
                            r_holding <= 1'b1;
`ifdef SPEEDGOAL_ACCEL_EN
                            r_rep     <= '0;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DELAY: begin
                    if (w_abort) begin
                        r_state   <= S_REL_DB;
                        r_cnt     <= '0;
                        r_holding <= 1'b0;
                    end else if (r_cnt == DLY_LAST) begin
                        r_pulse <= w_sel_mask;
                        r_cnt   <= '0;
                        r_state <= S_REPEAT;
`ifdef SPEEDGOAL_ACCEL_EN
                        r_rep   <= REP_W'(1);
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (w_abort) begin
                        r_state   <= S_REL_DB;
                        r_cnt     <= '0;
                        r_holding <= 1'b0;
                    end else if (r_cnt == w_period_last) begin
                        r_pulse <= w_sel_mask;
                        r_cnt   <= '0;
`ifdef SPEEDGOAL_ACCEL_EN
                        if (r_rep < REP_W'(FAST_AFTER)) begin
                            r_rep <= r_rep + REP_W'(1);
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REL_DB: begin
                    if (|w_pressed) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_holding <= 1'b0;
                end
            endcase
        end
    end

    assign up        = r_pulse[0];
    assign down      = r_pulse[1];
    assign goal_srst = r_pulse[2];
    assign holding   = r_holding;

endmodule
